// File: rtl/data_mem_responder.sv
// Data-memory responder: NUM_CHANNELS round-robin service channels front a
// word-addressed array and answer per-lane read/write requests after LATENCY cycles.
module data_mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int LATENCY       = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic [NUM_CHANNELS-1:0][2:0]             dbg_channel_state
);

  // Handshake: a lane raises valid with stable address/data and holds it until it
  // sees ready; ready then stays high (read_data valid) until valid is sampled low,
  // and clears on that edge. Ready never rises for a lane still waiting for a channel.

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CIW   = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int CNTW  = $clog2(LATENCY) + 1;

  typedef enum logic [2:0] {
    CH_IDLE        = 3'd0,
    CH_READ_WAIT   = 3'd1,
    CH_WRITE_WAIT  = 3'd2,
    CH_READ_RELAY  = 3'd3,
    CH_WRITE_RELAY = 3'd4
  } ch_state_t;

  ch_state_t                               state_q [NUM_CHANNELS];
  ch_state_t                               state_d [NUM_CHANNELS];
  logic [CIW-1:0]                          cons_q  [NUM_CHANNELS];
  logic [CIW-1:0]                          cons_d  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]                    addr_q  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]                    addr_d  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]                    wdata_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0]                    wdata_d [NUM_CHANNELS];
  logic [CNTW-1:0]                         cnt_q   [NUM_CHANNELS];
  logic [CNTW-1:0]                         cnt_d   [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]                claim_q, claim_d;
  logic [CIW-1:0]                          rr_ptr_q, rr_ptr_d;
  logic [NUM_CONSUMERS-1:0]                read_ready_q, read_ready_d;
  logic [NUM_CONSUMERS-1:0]                write_ready_q, write_ready_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] read_data_q, read_data_d;
  logic [DATA_BITS-1:0]                    mem_q [DEPTH];
  logic [DATA_BITS-1:0]                    mem_d [DEPTH];

  logic [NUM_CONSUMERS-1:0] picked;
  logic                     granted;
  logic                     found;
  logic [CIW-1:0]           last_idx;
  logic [CIW-1:0]           idx;
  logic [CIW-1:0]           cand;

  always_comb begin
    state_d       = state_q;
    cons_d        = cons_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    claim_d       = claim_q;
    rr_ptr_d      = rr_ptr_q;
    read_ready_d  = read_ready_q;
    write_ready_d = write_ready_q;
    read_data_d   = read_data_q;
    mem_d         = mem_q;
    picked        = '0;
    granted       = 1'b0;
    found         = 1'b0;
    last_idx      = '0;
    idx           = '0;
    cand          = '0;

    // Ascending channel order: lower channels grant first, higher channels win commits.
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      case (state_q[ch])
        CH_IDLE: begin
          found = 1'b0;
          idx   = '0;
          for (int i = 0; i < NUM_CONSUMERS; i++) begin
            cand = CIW'((int'(rr_ptr_q) + i) % NUM_CONSUMERS);
            if (!found && (consumer_read_valid[cand] || consumer_write_valid[cand]) &&
                !claim_q[cand] && !picked[cand]) begin
              found = 1'b1;
              idx   = cand;
            end
          end
          if (found) begin
            picked[idx]  = 1'b1;
            claim_d[idx] = 1'b1;
            cons_d[ch]   = idx;
            cnt_d[ch]    = CNTW'(LATENCY - 1);
            granted      = 1'b1;
            last_idx     = idx;
            // A lane presenting both valids gets its read first; the write waits.
            if (consumer_read_valid[idx]) begin
              state_d[ch] = CH_READ_WAIT;
              addr_d[ch]  = consumer_read_address[idx];
            end else begin
              state_d[ch] = CH_WRITE_WAIT;
              addr_d[ch]  = consumer_write_address[idx];
              wdata_d[ch] = consumer_write_data[idx];
            end
          end
        end
        CH_READ_WAIT: begin
          if (cnt_q[ch] == '0) begin
            // Reads sample the pre-edge array, so a same-edge write is not visible.
            read_data_d[cons_q[ch]]  = mem_q[addr_q[ch]];
            read_ready_d[cons_q[ch]] = 1'b1;
            state_d[ch]              = CH_READ_RELAY;
          end else begin
            cnt_d[ch] = cnt_q[ch] - 1'b1;
          end
        end
        CH_WRITE_WAIT: begin
          if (cnt_q[ch] == '0) begin
            mem_d[addr_q[ch]]         = wdata_q[ch];
            write_ready_d[cons_q[ch]] = 1'b1;
            state_d[ch]               = CH_WRITE_RELAY;
          end else begin
            cnt_d[ch] = cnt_q[ch] - 1'b1;
          end
        end
        CH_READ_RELAY: begin
          if (!consumer_read_valid[cons_q[ch]]) begin
            read_ready_d[cons_q[ch]] = 1'b0;
            claim_d[cons_q[ch]]      = 1'b0;
            state_d[ch]              = CH_IDLE;
          end
        end
        CH_WRITE_RELAY: begin
          if (!consumer_write_valid[cons_q[ch]]) begin
            write_ready_d[cons_q[ch]] = 1'b0;
            claim_d[cons_q[ch]]       = 1'b0;
            state_d[ch]               = CH_IDLE;
          end
        end
        default: state_d[ch] = CH_IDLE;
      endcase
    end

    if (granted) begin
      if (last_idx == CIW'(NUM_CONSUMERS - 1)) rr_ptr_d = '0;
      else                                      rr_ptr_d = last_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= CH_IDLE;
        cons_q[ch]  <= '0;
        addr_q[ch]  <= '0;
        wdata_q[ch] <= '0;
        cnt_q[ch]   <= '0;
      end
      for (int a = 0; a < DEPTH; a++) mem_q[a] <= '0;
      claim_q       <= '0;
      rr_ptr_q      <= '0;
      read_ready_q  <= '0;
      write_ready_q <= '0;
      read_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      cons_q        <= cons_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      mem_q         <= mem_d;
      claim_q       <= claim_d;
      rr_ptr_q      <= rr_ptr_d;
      read_ready_q  <= read_ready_d;
      write_ready_q <= write_ready_d;
      read_data_q   <= read_data_d;
    end
  end

  always_comb begin
    for (int ch = 0; ch < NUM_CHANNELS; ch++) dbg_channel_state[ch] = state_q[ch];
  end

  assign consumer_read_ready  = read_ready_q;
  assign consumer_write_ready = write_ready_q;
  assign consumer_read_data   = read_data_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one single-channel and one dual-channel
// instance, driven and sampled on the falling clock edge.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n [2];
  logic [3:0]      rv    [2];
  logic [3:0]      wv    [2];
  logic [3:0][7:0] raddr [2];
  logic [3:0][7:0] waddr [2];
  logic [3:0][7:0] wdat  [2];
  logic [3:0]      rr    [2];
  logic [3:0]      wr    [2];
  logic [3:0][7:0] rdata [2];
  logic [0:0][2:0] dbg_a;
  logic [1:0][2:0] dbg_b;

  int total;
  int pass_cnt;
  int fail_cnt;

  data_mem_responder #(.NUM_CHANNELS(1)) dut_a (
    .clk                    (clk),
    .reset                  (rst_n[0]),
    .consumer_read_valid    (rv[0]),
    .consumer_read_address  (raddr[0]),
    .consumer_read_ready    (rr[0]),
    .consumer_read_data     (rdata[0]),
    .consumer_write_valid   (wv[0]),
    .consumer_write_address (waddr[0]),
    .consumer_write_data    (wdat[0]),
    .consumer_write_ready   (wr[0]),
    .dbg_channel_state      (dbg_a)
  );

  data_mem_responder #(.NUM_CHANNELS(2)) dut_b (
    .clk                    (clk),
    .reset                  (rst_n[1]),
    .consumer_read_valid    (rv[1]),
    .consumer_read_address  (raddr[1]),
    .consumer_read_ready    (rr[1]),
    .consumer_read_data     (rdata[1]),
    .consumer_write_valid   (wv[1]),
    .consumer_write_address (waddr[1]),
    .consumer_write_data    (wdat[1]),
    .consumer_write_ready   (wr[1]),
    .dbg_channel_state      (dbg_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input int d, input bit is_rd, input int lane, input int exp_lat,
                          input string tag);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = is_rd ? rr[d][lane] : wr[d][lane];
    end
    check({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic read_txn(input int d, input int lane, input logic [7:0] addr,
                          input logic [7:0] exp_data, input string tag);
    raddr[d][lane] = addr;
    rv[d][lane]    = 1'b1;
    wait_rdy(d, 1'b1, lane, 3, tag);
    check({tag, "_data"}, rdata[d][lane], exp_data);
    @(negedge clk);
    check({tag, "_hold"}, rr[d][lane], 1);
    rv[d][lane] = 1'b0;
    @(negedge clk);
    check({tag, "_clear"}, rr[d][lane], 0);
  endtask

  task automatic write_txn(input int d, input int lane, input logic [7:0] addr,
                           input logic [7:0] data, input string tag);
    waddr[d][lane] = addr;
    wdat[d][lane]  = data;
    wv[d][lane]    = 1'b1;
    wait_rdy(d, 1'b0, lane, 3, tag);
    @(negedge clk);
    check({tag, "_hold"}, wr[d][lane], 1);
    wv[d][lane] = 1'b0;
    @(negedge clk);
    check({tag, "_clear"}, wr[d][lane], 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          exp_lane_q [$];
    int          exp_cyc_q  [$];
    logic [7:0]  exp_q      [$];
    int          cyc;
    int          done;
    bit          re0;
    bit          first0;

    total = 0; pass_cnt = 0; fail_cnt = 0;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b1;
      rv[d] = '0; wv[d] = '0; raddr[d] = '0; waddr[d] = '0; wdat[d] = '0;
    end

    // Reset both instances and check the idle state while reset is held.
    #1;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    @(negedge clk);
    check("rst_a_read_ready",  rr[0],    0);
    check("rst_a_write_ready", wr[0],    0);
    check("rst_a_read_data",   rdata[0], 0);
    check("rst_a_state",       dbg_a,    0);
    check("rst_b_read_ready",  rr[1],    0);
    check("rst_b_write_ready", wr[1],    0);
    check("rst_b_read_data",   rdata[1], 0);
    check("rst_b_state",       dbg_b,    0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Single-channel basics.
    read_txn (0, 2, 8'hFF, 8'h00, "rd_ff_cleared");
    write_txn(0, 0, 8'h10, 8'h5A, "wr_10");
    read_txn (0, 1, 8'h10, 8'h5A, "rd_10");
    write_txn(0, 3, 8'h20, 8'hA5, "wr_20");

    // Four-way contention; pointer is 0 here. Lane 0 re-requests right after its release.
    exp_lane_q = '{0, 1, 2, 3, 0};
    exp_cyc_q  = '{3, 7, 11, 15, 19};
    exp_q      = '{8'h5A, 8'hA5, 8'h00, 8'h00, 8'h5A};
    raddr[0][0] = 8'h10;
    raddr[0][1] = 8'h20;
    raddr[0][2] = 8'hFF;
    raddr[0][3] = 8'h11;
    rv[0] = 4'hF;
    cyc = 0; done = 0; re0 = 1'b0; first0 = 1'b1;
    while (done < 5 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (re0) begin
        rv[0][0] = 1'b1;
        re0 = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (rv[0][i] && rr[0][i] && done < 5) begin
          check("contention_order", i,           exp_lane_q.pop_front());
          check("contention_cycle", cyc,         exp_cyc_q.pop_front());
          check("contention_data",  rdata[0][i], exp_q.pop_front());
          rv[0][i] = 1'b0;
          done++;
          if (i == 0 && first0) begin
            re0    = 1'b1;
            first0 = 1'b0;
          end
        end
      end
    end
    check("contention_done", done, 5);
    @(negedge clk);
    check("contention_clear", rr[0], 0);

    // Two channels: simultaneous writes complete on the same edge.
    waddr[1][1] = 8'd3; wdat[1][1] = 8'h11;
    waddr[1][2] = 8'd4; wdat[1][2] = 8'h22;
    wv[1] = 4'b0110;
    wait_rdy(1, 1'b0, 1, 3, "dual_wr_lane1");
    check("dual_wr_lane2_same_edge", wr[1][2], 1);
    wv[1] = '0;
    @(negedge clk);
    check("dual_wr_clear", wr[1], 0);

    raddr[1][1] = 8'd3;
    raddr[1][2] = 8'd4;
    rv[1] = 4'b0110;
    wait_rdy(1, 1'b1, 1, 3, "dual_rd_lane1");
    check("dual_rd_lane2_same_edge", rr[1][2],    1);
    check("dual_rd_data1",           rdata[1][1], 8'h11);
    check("dual_rd_data2",           rdata[1][2], 8'h22);
    rv[1] = '0;
    @(negedge clk);
    check("dual_rd_clear", rr[1], 0);

    // Lane 0 holds its read for 5 cycles while lane 3 is served on the other channel.
    raddr[1][0] = 8'd3;
    rv[1][0] = 1'b1;
    wait_rdy(1, 1'b1, 0, 3, "held_lane0");
    raddr[1][3] = 8'd4;
    rv[1][3] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("held_ready", rr[1][0],    1);
      check("held_data",  rdata[1][0], 8'h11);
      if (k == 3) begin
        check("held_other_ready", rr[1][3],    1);
        check("held_other_data",  rdata[1][3], 8'h22);
        rv[1][3] = 1'b0;
      end
    end
    rv[1][0] = 1'b0;
    @(negedge clk);
    check("held_clear",       rr[1][0], 0);
    check("held_other_clear", rr[1][3], 0);

    // Reset during a pending write discards it and clears the array.
    write_txn(0, 3, 8'hFF, 8'h77, "wr_ff");
    read_txn (0, 3, 8'hFF, 8'h77, "rd_ff");
    waddr[0][2] = 8'h07;
    wdat[0][2]  = 8'h33;
    wv[0][2]    = 1'b1;
    @(negedge clk);
    check("midwr_state_write_wait", dbg_a, 3'd2);
    rst_n[0] = 1'b0;
    @(negedge clk);
    check("midwr_ready_in_reset", wr[0][2], 0);
    @(negedge clk);
    check("midwr_ready_in_reset2", wr[0][2], 0);
    wv[0][2] = 1'b0;
    rst_n[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midwr_ready_after_reset", wr[0][2], 0);
    end
    read_txn(0, 2, 8'h07, 8'h00, "rd_07_after_reset");
    read_txn(0, 3, 8'hFF, 8'h00, "rd_ff_after_reset");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
